// File: rtl/multicycle_control_fsm.sv
// Multicycle datapath sequencing controller: FETCH, DECODE, then one or two execute states per instruction.
// Optional CTRL_ILLEGAL_TRAP_EN: an undecoded instruction halts the machine instead of retiring as a NOP.
module multicycle_control_fsm #(
    parameter int OPW  = 6,
    parameter int ALUW = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instr,
    output logic            PCWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            secondRound,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [ALUW-1:0] ALUControl,
    output logic [1:0]      PCSrc,
    output logic            memWrite,
    output logic            memToReg,
    output logic            regDst,
    output logic            regWriteEnable,
    output logic            jump,
    output logic            jumpReg,
    output logic [3:0]      state,
    output logic            illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_RTYPE  = 4'd2,
        S_NORI   = 4'd3,
        S_LWADDR = 4'd4,
        S_LWWB   = 4'd5,
        S_SW     = 4'd6,
        S_BLEU   = 4'd7,
        S_JMP    = 4'd8,
        S_JAL    = 4'd9,
        S_JR     = 4'd10,
        S_NOP    = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_NORI  = OPW'(6'b001110);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_BLEU  = OPW'(6'b000111);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);

    localparam logic [OPW-1:0] FN_ADD  = OPW'(6'b100000);
    localparam logic [OPW-1:0] FN_AND  = OPW'(6'b100100);
    localparam logic [OPW-1:0] FN_NOR  = OPW'(6'b100111);
    localparam logic [OPW-1:0] FN_NOT  = OPW'(6'b101000);
    localparam logic [OPW-1:0] FN_ROL  = OPW'(6'b000100);
    localparam logic [OPW-1:0] FN_ROR  = OPW'(6'b000110);
    localparam logic [OPW-1:0] FN_JR   = OPW'(6'b001000);

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(5'b00000);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(5'b00001);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(5'b00010);
    localparam logic [ALUW-1:0] ALU_NOR = ALUW'(5'b00011);
    localparam logic [ALUW-1:0] ALU_NOT = ALUW'(5'b00100);
    localparam logic [ALUW-1:0] ALU_ROL = ALUW'(5'b00101);
    localparam logic [ALUW-1:0] ALU_ROR = ALUW'(5'b00110);

    state_t          state_q, state_d;
    logic            illegal_q, illegal_d;
    logic [OPW-1:0]  opcode, funct;
    state_t          dispatch;
    logic            decode_ok;
    logic [ALUW-1:0] alu_rtype;
    logic            unused_instr_bits;

    assign opcode = instr[31 -: OPW];
    assign funct  = instr[OPW-1:0];
    assign unused_instr_bits = ^instr[31-OPW:OPW];

    always_comb begin
        dispatch  = S_FETCH;
        decode_ok = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_AND, FN_NOR, FN_NOT, FN_ROL, FN_ROR: dispatch = S_RTYPE;
                    FN_JR:   dispatch  = S_JR;
                    default: decode_ok = 1'b0;
                endcase
            end
            OP_NORI: dispatch  = S_NORI;
            OP_LW:   dispatch  = S_LWADDR;
            OP_SW:   dispatch  = S_SW;
            OP_BLEU: dispatch  = S_BLEU;
            OP_J:    dispatch  = S_JMP;
            OP_JAL:  dispatch  = S_JAL;
            default: decode_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_rtype = ALU_ADD;
        case (funct)
            FN_AND:  alu_rtype = ALU_AND;
            FN_NOR:  alu_rtype = ALU_NOR;
            FN_NOT:  alu_rtype = ALU_NOT;
            FN_ROL:  alu_rtype = ALU_ROL;
            FN_ROR:  alu_rtype = ALU_ROR;
            default: alu_rtype = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        illegal_d      = illegal_q;
        PCWrite        = 1'b0;
        IorD           = 1'b0;
        IRWrite        = 1'b0;
        secondRound    = 1'b0;
        ALUSrcA        = 1'b0;
        ALUSrcB        = 2'b00;
        ALUControl     = '0;
        PCSrc          = 2'b00;
        memWrite       = 1'b0;
        memToReg       = 1'b0;
        regDst         = 1'b0;
        regWriteEnable = 1'b0;
        jump           = 1'b0;
        jumpReg        = 1'b0;

        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                secondRound = 1'b1;
                if (decode_ok) begin
                    state_d = dispatch;
                end else begin
                    illegal_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_NOP;
`endif
                end
            end
            S_RTYPE: begin
                secondRound    = 1'b1;
                ALUSrcA        = 1'b1;
                ALUControl     = alu_rtype;
                regDst         = 1'b1;
                regWriteEnable = 1'b1;
                PCWrite        = 1'b1;
                state_d        = S_FETCH;
            end
            S_NORI: begin
                secondRound    = 1'b1;
                ALUSrcA        = 1'b1;
                ALUSrcB        = 2'b10;
                ALUControl     = ALU_NOR;
                regWriteEnable = 1'b1;
                PCWrite        = 1'b1;
                state_d        = S_FETCH;
            end
            S_LWADDR: begin
                secondRound = 1'b1;
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALUControl  = ALU_ADD;
                IorD        = 1'b1;
                state_d     = S_LWWB;
            end
            S_LWWB: begin
                secondRound    = 1'b1;
                IorD           = 1'b1;
                ALUSrcA        = 1'b1;
                ALUSrcB        = 2'b10;
                memToReg       = 1'b1;
                regWriteEnable = 1'b1;
                PCWrite        = 1'b1;
                state_d        = S_FETCH;
            end
            S_SW: begin
                secondRound = 1'b1;
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALUControl  = ALU_ADD;
                IorD        = 1'b1;
                memWrite    = 1'b1;
                PCWrite     = 1'b1;
                state_d     = S_FETCH;
            end
            S_BLEU: begin
                secondRound = 1'b1;
                ALUSrcA     = 1'b1;
                ALUControl  = ALU_SUB;
                PCSrc       = 2'b10;
                PCWrite     = 1'b1;
                state_d     = S_FETCH;
            end
            S_JMP: begin
                secondRound = 1'b1;
                PCSrc       = 2'b01;
                PCWrite     = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                secondRound    = 1'b1;
                PCSrc          = 2'b01;
                PCWrite        = 1'b1;
                jump           = 1'b1;
                regWriteEnable = 1'b1;
                state_d        = S_FETCH;
            end
            S_JR: begin
                secondRound = 1'b1;
                PCSrc       = 2'b01;
                jumpReg     = 1'b1;
                PCWrite     = 1'b1;
                state_d     = S_FETCH;
            end
            S_NOP: begin
                secondRound = 1'b1;
                PCWrite     = 1'b1;
                state_d     = S_FETCH;
            end
            S_HALT: begin
                illegal_d = 1'b1;
                state_d   = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset gates every output in the same cycle so an aborted instruction commits nothing.
        if (reset) begin
            PCWrite        = 1'b0;
            IorD           = 1'b0;
            IRWrite        = 1'b0;
            secondRound    = 1'b0;
            ALUSrcA        = 1'b0;
            ALUSrcB        = 2'b00;
            ALUControl     = '0;
            PCSrc          = 2'b00;
            memWrite       = 1'b0;
            memToReg       = 1'b0;
            regDst         = 1'b0;
            regWriteEnable = 1'b0;
            jump           = 1'b0;
            jumpReg        = 1'b0;
        end
    end

    assign state   = reset ? 4'd0 : state_q;
    assign illegal = reset ? 1'b0 : illegal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, multi-cycle corner sequences, and
// randomized instructions checked against a per-instruction effect model.
module tb_multicycle_control_fsm;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic        PCWrite, IorD, IRWrite, secondRound, ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [4:0]  ALUControl;
    logic [1:0]  PCSrc;
    logic        memWrite, memToReg, regDst, regWriteEnable, jump, jumpReg;
    logic [3:0]  state;
    logic        illegal;

    int unsigned tests  = 0;
    int unsigned failed = 0;
    logic        model_ill;

    multicycle_control_fsm #(.OPW(6), .ALUW(5)) dut (
        .clock(clock), .reset(reset), .instr(instr),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .secondRound(secondRound),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst),
        .regWriteEnable(regWriteEnable), .jump(jump), .jumpReg(jumpReg),
        .state(state), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int unsigned ncyc;
        logic [15:0] sts;
        logic [19:0] last;
    } vec_t;

    typedef struct {
        int unsigned ncyc;
        logic        ill;
        logic [1:0]  pcsrc;
        logic [4:0]  alu;
        int unsigned rwe;
        int unsigned mw;
    } exp_t;

    function automatic logic [19:0] mk(input logic pcw, input logic iord, input logic irw,
                                       input logic sr, input logic asa, input logic [1:0] asb,
                                       input logic [4:0] alu, input logic [1:0] pcs,
                                       input logic mw, input logic m2r, input logic rd,
                                       input logic rwe, input logic j, input logic jr);
        return {pcw, iord, irw, sr, asa, asb, alu, pcs, mw, m2r, rd, rwe, j, jr};
    endfunction

    function automatic logic [19:0] ctl();
        return {PCWrite, IorD, IRWrite, secondRound, ALUSrcA, ALUSrcB, ALUControl, PCSrc,
                memWrite, memToReg, regDst, regWriteEnable, jump, jumpReg};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected architectural effect of one instruction, straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        e.ncyc = 3; e.ill = 1'b0; e.pcsrc = 2'd0; e.alu = 5'd0; e.rwe = 0; e.mw = 0;
        case (op)
            6'd0: begin
                e.rwe = 1;
                case (fn)
                    6'h20: e.alu = 5'd0;
                    6'h24: e.alu = 5'd2;
                    6'h27: e.alu = 5'd3;
                    6'h28: e.alu = 5'd4;
                    6'h04: e.alu = 5'd5;
                    6'h06: e.alu = 5'd6;
                    6'h08: begin e.rwe = 0; e.pcsrc = 2'd1; end
                    default: begin e.rwe = 0; e.ill = 1'b1; end
                endcase
            end
            6'h0E: begin e.rwe = 1; e.alu = 5'd3; end
            6'h23: begin e.rwe = 1; e.ncyc = 4; end
            6'h2B: e.mw = 1;
            6'h07: begin e.alu = 5'd1; e.pcsrc = 2'd2; end
            6'h02: e.pcsrc = 2'd1;
            6'h03: begin e.pcsrc = 2'd1; e.rwe = 1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [19:0] c_fetch, c_decode;
        c_fetch  = mk(0, 0, 1, 0, 0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        c_decode = mk(0, 0, 0, 1, 0, 2'd0, 5'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        instr = v.instr;
        #1;
        for (int unsigned c = 0; c < v.ncyc; c++) begin
            check($sformatf("%s_state%0d", v.name, c), {28'd0, state}, {28'd0, v.sts[15-4*c -: 4]});
            if (c == 0) check($sformatf("%s_fetch_ctl", v.name), {12'd0, ctl()}, {12'd0, c_fetch});
            if (c == 1) check($sformatf("%s_decode_ctl", v.name), {12'd0, ctl()}, {12'd0, c_decode});
            if (c == v.ncyc - 1) check($sformatf("%s_exec_ctl", v.name), {12'd0, ctl()}, {12'd0, v.last});
            tick();
        end
        check($sformatf("%s_return", v.name), {28'd0, state}, 32'd0);
    endtask

    task automatic run_rand(input logic [31:0] w, input int unsigned idx);
        exp_t        e;
        int unsigned cyc, pcw_cnt, pcw_at, rwe, mw, viol;
        logic [4:0]  alu_at;
        logic [1:0]  pcs_at;
        e = model(w);
        instr = w;
        #1;
        cyc = 0; pcw_cnt = 0; pcw_at = 0; rwe = 0; mw = 0; viol = 0;
        alu_at = '0; pcs_at = '0;
        for (int k = 0; k < 8; k++) begin
            if ((PCWrite && IRWrite) || (memWrite && regWriteEnable)) viol++;
            if (state != 4'd15 && secondRound != (state != 4'd0)) viol++;
            if (PCWrite) begin pcw_cnt++; pcw_at = cyc; alu_at = ALUControl; pcs_at = PCSrc; end
            if (regWriteEnable) rwe++;
            if (memWrite) mw++;
            tick();
            cyc++;
            if (state == 4'd0 || state == 4'd15) break;
        end
        model_ill = model_ill | e.ill;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (e.ill) begin
            check($sformatf("rand%0d_halt", idx), {28'd0, state}, 32'd15);
            check($sformatf("rand%0d_halt_ctl", idx), {12'd0, ctl()}, 32'd0);
            check($sformatf("rand%0d_halt_pcw", idx), pcw_cnt, 32'd0);
            check($sformatf("rand%0d_illegal", idx), {31'd0, illegal}, 32'd1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            model_ill = 1'b0;
            #1;
            check($sformatf("rand%0d_recover", idx), {28'd0, state}, 32'd0);
            return;
        end
`endif
        check($sformatf("rand%0d_cycles", idx), cyc, e.ncyc);
        check($sformatf("rand%0d_pcw_count", idx), pcw_cnt, 32'd1);
        check($sformatf("rand%0d_pcw_last", idx), pcw_at, e.ncyc - 1);
        check($sformatf("rand%0d_pcsrc", idx), {30'd0, pcs_at}, {30'd0, e.pcsrc});
        check($sformatf("rand%0d_alu", idx), {27'd0, alu_at}, {27'd0, e.alu});
        check($sformatf("rand%0d_regwrite", idx), rwe, e.rwe);
        check($sformatf("rand%0d_memwrite", idx), mw, e.mw);
        check($sformatf("rand%0d_invariants", idx), viol, 32'd0);
        check($sformatf("rand%0d_illegal", idx), {31'd0, illegal}, {31'd0, model_ill});
    endtask

    function automatic logic [31:0] gen_instr();
        logic [5:0] fn_tab [6];
        logic [5:0] op, fn;
        int unsigned k;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h24; fn_tab[2] = 6'h27;
        fn_tab[3] = 6'h28; fn_tab[4] = 6'h04; fn_tab[5] = 6'h06;
        k = $urandom_range(0, 13);
        if (k < 6) return {6'd0, 20'($urandom), fn_tab[k]};
        case (k)
            6:  return {6'd0, 20'($urandom), 6'h08};
            7:  return {6'h0E, 26'($urandom)};
            8:  return {6'h23, 26'($urandom)};
            9:  return {6'h2B, 26'($urandom)};
            10: return {6'h07, 26'($urandom)};
            11: return {6'h02, 26'($urandom)};
            12: return {6'h03, 26'($urandom)};
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    do fn = 6'($urandom);
                    while (fn inside {6'h20, 6'h24, 6'h27, 6'h28, 6'h04, 6'h06, 6'h08});
                    return {6'd0, 20'($urandom), fn};
                end
                do op = 6'($urandom);
                while (op inside {6'h00, 6'h0E, 6'h23, 6'h2B, 6'h07, 6'h02, 6'h03});
                return {op, 26'($urandom)};
            end
        endcase
    endfunction

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"add",  32'h00851020, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd0,2'd0,0,0,1,1,0,0)};
        vecs[1]  = '{"andr", 32'h00851024, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd2,2'd0,0,0,1,1,0,0)};
        vecs[2]  = '{"norr", 32'h00851027, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd3,2'd0,0,0,1,1,0,0)};
        vecs[3]  = '{"notr", 32'h00851028, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd4,2'd0,0,0,1,1,0,0)};
        vecs[4]  = '{"rolv", 32'h00851004, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd5,2'd0,0,0,1,1,0,0)};
        vecs[5]  = '{"rorv", 32'h00851006, 3, 16'h0120, mk(1,0,0,1,1,2'd0,5'd6,2'd0,0,0,1,1,0,0)};
        vecs[6]  = '{"jr",   32'h03E00008, 3, 16'h01A0, mk(1,0,0,1,0,2'd0,5'd0,2'd1,0,0,0,0,0,1)};
        vecs[7]  = '{"nori", 32'h3882FFFF, 3, 16'h0130, mk(1,0,0,1,1,2'd2,5'd3,2'd0,0,0,0,1,0,0)};
        vecs[8]  = '{"lw",   32'h8C820004, 4, 16'h0145, mk(1,1,0,1,1,2'd2,5'd0,2'd0,0,1,0,1,0,0)};
        vecs[9]  = '{"sw",   32'hAC820004, 3, 16'h0160, mk(1,1,0,1,1,2'd2,5'd0,2'd0,1,0,0,0,0,0)};
        vecs[10] = '{"bleu", 32'h1C850003, 3, 16'h0170, mk(1,0,0,1,1,2'd0,5'd1,2'd2,0,0,0,0,0,0)};
        vecs[11] = '{"jal",  32'h0C000010, 3, 16'h0190, mk(1,0,0,1,0,2'd0,5'd0,2'd1,0,0,0,1,1,0)};

        reset = 1'b1;
        instr = 32'h00851020;
        model_ill = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("reset%0d_state", i), {28'd0, state}, 32'd0);
            check($sformatf("reset%0d_ctl", i), {12'd0, ctl()}, 32'd0);
            check($sformatf("reset%0d_illegal", i), {31'd0, illegal}, 32'd0);
        end
        reset = 1'b0;
        #1;
        check("release_irwrite", {12'd0, ctl()}, {12'd0, mk(0,0,1,0,0,2'd0,5'd0,2'd0,0,0,0,0,0,0)});

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        check("legal_not_illegal", {31'd0, illegal}, 32'd0);

        // Reset landing in LWADDR must abort the load before its write-back.
        instr = 32'h8C820004;
        tick();
        tick();
        check("lwabort_state", {28'd0, state}, 32'd4);
        check("lwabort_addr_ctl", {12'd0, ctl()}, {12'd0, mk(0,1,0,1,1,2'd2,5'd0,2'd0,0,0,0,0,0,0)});
        reset = 1'b1;
        #1;
        check("lwabort_ctl_in_reset", {12'd0, ctl()}, 32'd0);
        tick();
        check("lwabort_regwrite", {31'd0, regWriteEnable}, 32'd0);
        reset = 1'b0;
        #1;
        check("lwabort_state_after", {28'd0, state}, 32'd0);
        check("lwabort_fetch", {31'd0, IRWrite}, 32'd1);
        tick();
        check("lwabort_decode", {28'd0, state}, 32'd1);
        tick();
        check("lwabort_refetch_addr", {28'd0, state}, 32'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;

        // Undecoded opcode.
        instr = 32'hFC000000;
        tick();
        check("ill_decode_state", {28'd0, state}, 32'd1);
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            check($sformatf("ill_halt_state%0d", i), {28'd0, state}, 32'd15);
            check($sformatf("ill_halt_pcw%0d", i), {31'd0, PCWrite}, 32'd0);
            check($sformatf("ill_halt_flag%0d", i), {31'd0, illegal}, 32'd1);
            tick();
        end
        check("ill_halt_ctl", {12'd0, ctl()}, 32'd0);
`else
        check("ill_nop_ctl", {12'd0, ctl()}, {12'd0, mk(1,0,0,1,0,2'd0,5'd0,2'd0,0,0,0,0,0,0)});
        check("ill_nop_flag", {31'd0, illegal}, 32'd1);
        tick();
        check("ill_nop_return", {28'd0, state}, 32'd0);
        check("ill_sticky", {31'd0, illegal}, 32'd1);
        instr = 32'h00851020;
        tick();
        tick();
        tick();
        check("ill_sticky_after_add", {31'd0, illegal}, 32'd1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("ill_cleared_by_reset", {31'd0, illegal}, 32'd0);
        model_ill = 1'b0;

        for (int unsigned i = 0; i < 300; i++) run_rand(gen_instr(), i);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
